eth_cfg_seq: RTL and testbench
==============================

// Module: eth_cfg_seq
// PURPOSE
//  Boot-time configuration sequencer for the Ethernet MAC. It is a Wishbone master on the MAC's 10-bit word-addressed slave port.
//  On start_i it programs, in order:
//    - MAC address
//    - TX buffer-descriptor count
//    - interrupt mask
//    - MII clock divider
//    - optionally one PHY register, written via MIIM with busy polling
//  It then enables TX/RX in MODER. Sits between the SoC reset/boot logic and the MAC slave port, muxed with the CPU port.
// PARAMETERS
//  TX_BD_NUM   default 64       value written to TX_BD_NUM (word 0x08)
//  INT_MASK    default 32'h7F   value written to INT_MASK (word 0x02)
//  MII_CLKDIV  default 8'd40    MIIMODER[7:0] divider (word 0x0A)
//  MODER_VAL   default 32'hA403 final MODER: PAD, CRCEN, FULLD, TXEN, RXEN (word 0x00)
//  PHY_ADDR    default 5'd1     MIIADDRESS FIAD
//  POLL_MAX    default 1023     max MIISTATUS reads before timeout; counter width = $clog2(POLL_MAX+1)
// PORTS
//  wb_clk_i     in  1  clock
//  wb_rst_n_i   in  1  synchronous reset, active low
//  start_i      in  1  level; rising edge (registered compare) launches sequence from IDLE/DONE/FAIL
//  mac_addr_i   in  48 MAC address, [47:40] = first byte on wire
//  phy_reg_i    in  5  PHY register index (RGAD)
//  phy_dat_i    in  16 PHY register write data
//  m_wb_adr_o   out 10 word address to MAC slave
//  m_wb_dat_o   out 32 write data
//  m_wb_dat_i   in  32 read data
//  m_wb_sel_o   out 4  always 4'hF while stb
//  m_wb_we_o    out 1  1 = write
//  m_wb_cyc_o   out 1  cycle
//  m_wb_stb_o   out 1  strobe
//  m_wb_ack_i   in  1  acknowledge
//  m_wb_err_i   in  1  bus error
//  busy_o       out 1  sequence in progress
//  done_o       out 1  sticky; sequence completed
//  err_o        out 1  sticky; bus error or poll timeout
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; step=0; poll_cnt=0; start edge register=0.
//  - States: IDLE, REQ, WAIT, POLL_REQ, POLL_WAIT, DONE, FAIL.
//  - IDLE/DONE/FAIL + start rise -> REQ with step=0; done_o and err_o cleared; busy_o=1.
//  - REQ: drive adr/dat/we from step table; cyc=stb=1 from the next edge -> WAIT.
//  - WAIT: hold all outputs stable until ack or err (no timeout on plain writes).
//      - ack: cyc=stb=0 on the next edge. One idle cycle between accesses. step++ -> REQ, or next phase.
//      - err: -> FAIL.
//  - Write table, word address: data:
//      - 0x10 : mac[31:0]
//      - 0x11 : {16'h0, mac[47:32]}
//      - 0x08 : TX_BD_NUM
//      - 0x02 : INT_MASK
//      - 0x0A : MII_CLKDIV
//      - [PHY phase, see CONFIGURATION]
//      - 0x00 : MODER_VAL
//  - Write latency: 1 cycle REQ plus N wait cycles, N = slave ack latency.
//  - PHY phase:
//      - write 0x0C MIIADDRESS = {19'h0, phy_reg_i, 3'h0, PHY_ADDR}
//      - write 0x0D MIITX_DATA = {16'h0, phy_dat_i}
//      - write 0x0B MIICOMMAND = 32'h4 (WCTRLDATA)
//      - then poll read 0x0F MIISTATUS (we=0) until bit1 (BUSY) = 0
//      - each completed read with BUSY=1 increments poll_cnt
//      - poll_cnt == POLL_MAX and BUSY still 1 -> FAIL
//  - DONE: busy_o=0, done_o=1. FAIL: busy_o=0, err_o=1, bus idle.
//  - start_i rise while busy_o=1: ignored.
//  - Reset mid-access: cyc/stb drop on that edge, no completion expected.
//  - ack and err asserted together: err wins.
//  - Input sampling:
//      - mac_addr_i / phy_* are sampled into the table only when the start edge is accepted.
//      - changes during a sequence have no effect.
// CONFIGURATION
//  ETH_CFG_PHY_EN
//    - defined: PHY phase (3 writes + poll) is inserted between the MIIMODER and MODER writes.
//    - undefined: phase and poll counter are not built; sequence is 6 writes.
//    - phy_reg_i and phy_dat_i ports remain present but are unused.
// TESTING
//  1 Zero-wait slave, ETH_CFG_PHY_EN undefined, start rise; mac=48'h0A1B2C3D4E5F
//      -> writes 0x10:32'h2C3D4E5F, 0x11:32'h0A1B, 0x08:64, 0x02:7F, 0x0A:40, 0x00:A403 in order
//      -> done_o=1, busy_o=0, err_o=0.
//  2 Slave ack delayed 3 cycles on every access
//      -> adr/dat/we/stb held stable during each wait
//      -> exactly 6 accesses, done_o=1.
//  3 ETH_CFG_PHY_EN, MIISTATUS BUSY=1 for 5 reads then 0
//      -> 6 status reads, then MODER write, done_o=1
//      -> MIIADDRESS write = 32'h00000101 for phy_reg_i=1, PHY_ADDR=1.
//  4 ETH_CFG_PHY_EN, POLL_MAX=7, BUSY stuck 1
//      -> FAIL after 7 reads, err_o=1, no MODER write issued.
//  5 m_wb_err_i on the 3rd access (0x08)
//      -> FAIL next cycle, cyc=0, err_o=1; a new start rise clears err_o and reruns from step 0.
//  6 wb_rst_n_i low during the WAIT of access 2
//      -> all outputs 0 next edge; start_i held high through reset does not launch until it falls and rises.

Source files
------------

// File: rtl/eth_cfg_seq.sv
// Boot-time Wishbone master that programs the Ethernet MAC (address, BD count, IRQ mask, MII divider, MODER).
// Define ETH_CFG_PHY_EN to also write one PHY register through MIIM and poll MIISTATUS.BUSY.
module eth_cfg_seq #(
    parameter int unsigned TX_BD_NUM  = 64,
    parameter logic [31:0] INT_MASK   = 32'h7F,
    parameter logic [7:0]  MII_CLKDIV = 8'd40,
    parameter logic [31:0] MODER_VAL  = 32'hA403,
    parameter logic [4:0]  PHY_ADDR   = 5'd1,
    parameter int unsigned POLL_MAX   = 1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        start_i,
    input  logic [47:0] mac_addr_i,
    input  logic [4:0]  phy_reg_i,
    input  logic [15:0] phy_dat_i,
    output logic [9:0]  m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    input  logic [31:0] m_wb_dat_i,
    output logic [3:0]  m_wb_sel_o,
    output logic        m_wb_we_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic        m_wb_ack_i,
    input  logic        m_wb_err_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);
`ifdef ETH_CFG_PHY_EN
    localparam int PCW = $clog2(POLL_MAX + 1);
    localparam logic [3:0] LAST_CFG   = 4'd7;
    localparam logic [3:0] MODER_STEP = 4'd8;
`else
    localparam logic [3:0] MODER_STEP = 4'd5;
`endif

    typedef enum logic [2:0] {IDLE, REQ, WAIT, POLL_REQ, POLL_WAIT, DONE, FAIL} state_t;
    typedef struct packed {
        logic [9:0]  adr;
        logic [31:0] dat;
        logic        we;
    } wb_req_t;

    state_t      state;
    logic [3:0]  step;
    logic        start_q;
    logic        start_armed;
    logic        start_rise;
    logic [47:0] mac_q;
    wb_req_t     req;

`ifdef ETH_CFG_PHY_EN
    logic [PCW-1:0] poll_cnt;
    logic [4:0]     phy_reg_q;
    logic [15:0]    phy_dat_q;
    logic           unused_rd;
    assign unused_rd = ^{m_wb_dat_i[31:2], m_wb_dat_i[0]};
`else
    logic unused_in;
    assign unused_in = ^{phy_reg_i, phy_dat_i, m_wb_dat_i, PHY_ADDR, 32'(POLL_MAX)};
`endif

    // start held high across reset must first be seen low before a rise counts
    assign start_rise = start_i & ~start_q & start_armed;

    always_comb begin
        req = '{adr: 10'h000, dat: MODER_VAL, we: 1'b1};
        case (step)
            4'd0: req = '{adr: 10'h010, dat: mac_q[31:0], we: 1'b1};
            4'd1: req = '{adr: 10'h011, dat: {16'h0, mac_q[47:32]}, we: 1'b1};
            4'd2: req = '{adr: 10'h008, dat: 32'(TX_BD_NUM), we: 1'b1};
            4'd3: req = '{adr: 10'h002, dat: INT_MASK, we: 1'b1};
            4'd4: req = '{adr: 10'h00A, dat: {24'h0, MII_CLKDIV}, we: 1'b1};
`ifdef ETH_CFG_PHY_EN
            4'd5: req = '{adr: 10'h00C, dat: {19'h0, phy_reg_q, 3'h0, PHY_ADDR}, we: 1'b1};
            4'd6: req = '{adr: 10'h00D, dat: {16'h0, phy_dat_q}, we: 1'b1};
            4'd7: req = '{adr: 10'h00B, dat: 32'h4, we: 1'b1};
`endif
            default: req = '{adr: 10'h000, dat: MODER_VAL, we: 1'b1};
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state       <= IDLE;
            step        <= '0;
            start_q     <= 1'b0;
            start_armed <= 1'b0;
            mac_q       <= '0;
            m_wb_adr_o  <= '0;
            m_wb_dat_o  <= '0;
            m_wb_sel_o  <= '0;
            m_wb_we_o   <= 1'b0;
            m_wb_cyc_o  <= 1'b0;
            m_wb_stb_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
`ifdef ETH_CFG_PHY_EN
            poll_cnt    <= '0;
            phy_reg_q   <= '0;
            phy_dat_q   <= '0;
`endif
        end else begin
            start_q <= start_i;
            if (!start_i) start_armed <= 1'b1;
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start_rise) begin
                        state  <= REQ;
                        step   <= '0;
                        busy_o <= 1'b1;
                        done_o <= 1'b0;
                        err_o  <= 1'b0;
                        mac_q  <= mac_addr_i;
`ifdef ETH_CFG_PHY_EN
                        poll_cnt  <= '0;
                        phy_reg_q <= phy_reg_i;
                        phy_dat_q <= phy_dat_i;
`endif
                    end
                end
                REQ: begin
                    m_wb_adr_o <= req.adr;
                    m_wb_dat_o <= req.dat;
                    m_wb_we_o  <= req.we;
                    m_wb_sel_o <= 4'hF;
                    m_wb_cyc_o <= 1'b1;
                    m_wb_stb_o <= 1'b1;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (m_wb_err_i || m_wb_ack_i) begin
                        m_wb_cyc_o <= 1'b0;
                        m_wb_stb_o <= 1'b0;
                        m_wb_sel_o <= '0;
                        m_wb_we_o  <= 1'b0;
                    end
                    if (m_wb_err_i) begin
                        busy_o <= 1'b0;
                        err_o  <= 1'b1;
                        state  <= FAIL;
                    end else if (m_wb_ack_i) begin
                        if (step == MODER_STEP) begin
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                            state  <= DONE;
`ifdef ETH_CFG_PHY_EN
                        end else if (step == LAST_CFG) begin
                            state <= POLL_REQ;
`endif
                        end else begin
                            step  <= step + 4'd1;
                            state <= REQ;
                        end
                    end
                end
`ifdef ETH_CFG_PHY_EN
                POLL_REQ: begin
                    m_wb_adr_o <= 10'h00F;
                    m_wb_we_o  <= 1'b0;
                    m_wb_sel_o <= 4'hF;
                    m_wb_cyc_o <= 1'b1;
                    m_wb_stb_o <= 1'b1;
                    state      <= POLL_WAIT;
                end
                POLL_WAIT: begin
                    if (m_wb_err_i || m_wb_ack_i) begin
                        m_wb_cyc_o <= 1'b0;
                        m_wb_stb_o <= 1'b0;
                        m_wb_sel_o <= '0;
                    end
                    if (m_wb_err_i) begin
                        busy_o <= 1'b0;
                        err_o  <= 1'b1;
                        state  <= FAIL;
                    end else if (m_wb_ack_i) begin
                        if (!m_wb_dat_i[1]) begin
                            step  <= MODER_STEP;
                            state <= REQ;
                        end else begin
                            // this read still saw BUSY; give up once POLL_MAX such reads are done
                            poll_cnt <= poll_cnt + 1'b1;
                            if (poll_cnt == PCW'(POLL_MAX - 1)) begin
                                busy_o <= 1'b0;
                                err_o  <= 1'b1;
                                state  <= FAIL;
                            end else begin
                                state <= POLL_REQ;
                            end
                        end
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_eth_cfg_seq.sv
// Self-checking bench for eth_cfg_seq: Wishbone slave model logs accesses, main process scores them.
// PHY tests are compiled in when ETH_CFG_PHY_EN is defined.
module tb_eth_cfg_seq;
    localparam int POLL_MAX = 7;
`ifdef ETH_CFG_PHY_EN
    localparam bit PHY_BUILD = 1'b1;
`else
    localparam bit PHY_BUILD = 1'b0;
`endif

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [47:0] mac_addr_i = '0;
    logic [4:0]  phy_reg_i = 5'd1;
    logic [15:0] phy_dat_i = 16'hBEEF;
    logic [9:0]  m_wb_adr_o;
    logic [31:0] m_wb_dat_o;
    logic [31:0] m_wb_dat_i = '0;
    logic [3:0]  m_wb_sel_o;
    logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o;
    logic        m_wb_ack_i = 1'b0;
    logic        m_wb_err_i = 1'b0;
    logic        busy_o, done_o, err_o;

    eth_cfg_seq #(.POLL_MAX(POLL_MAX)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .start_i(start_i),
        .mac_addr_i(mac_addr_i), .phy_reg_i(phy_reg_i), .phy_dat_i(phy_dat_i),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_dat_i(m_wb_dat_i),
        .m_wb_sel_o(m_wb_sel_o), .m_wb_we_o(m_wb_we_o), .m_wb_cyc_o(m_wb_cyc_o),
        .m_wb_stb_o(m_wb_stb_o), .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct { logic [9:0] adr; logic [31:0] dat; logic we; } acc_t;
    typedef struct { logic [9:0] adr; logic [31:0] dat; logic we; logic [3:0] sel; logic stable; } log_t;
    typedef struct { logic [47:0] mac; int dly; int err_step; int n_acc; logic exp_done; logic exp_err; } vec_t;

    int   checks = 0;
    int   failures = 0;
    acc_t exp_q[$];
    log_t acc_log[$];
    int   log_rd = 0;

    // slave controls (written by main process only)
    int ack_dly = 0;
    int err_at = -1;
    int busy_until = 0;

    // slave state (written by slave process only)
    int          acc_cnt = 0;
    int          rd_cnt = 0;
    int          wcnt = 0;
    logic [9:0]  f_adr = '0;
    logic [31:0] f_dat = '0;
    logic        f_we = 1'b0;
    logic [3:0]  f_sel = '0;
    logic        f_stable = 1'b1;

    always @(negedge wb_clk_i) begin
        if (m_wb_cyc_o && m_wb_stb_o && !m_wb_ack_i && !m_wb_err_i) begin
            if (wcnt == 0) begin
                f_adr = m_wb_adr_o; f_dat = m_wb_dat_o; f_we = m_wb_we_o; f_sel = m_wb_sel_o;
                f_stable = 1'b1;
            end else if (m_wb_adr_o !== f_adr || m_wb_dat_o !== f_dat ||
                         m_wb_we_o !== f_we || m_wb_sel_o !== f_sel) begin
                f_stable = 1'b0;
            end
            if (wcnt >= ack_dly) begin
                acc_log.push_back('{f_adr, f_dat, f_we, f_sel, f_stable});
                if (!f_we) begin
                    m_wb_dat_i = (rd_cnt < busy_until) ? 32'h2 : 32'h0;
                    rd_cnt++;
                end
                if (acc_cnt == err_at) m_wb_err_i = 1'b1;
                else m_wb_ack_i = 1'b1;
                acc_cnt++;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else if (!m_wb_stb_o) begin
            m_wb_ack_i = 1'b0;
            m_wb_err_i = 1'b0;
            wcnt = 0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference access list for one sequence; n == 0 keeps all of it
    task automatic push_exp(input logic [47:0] mac, input int n_reads, input logic with_moder, input int n);
        acc_t s[$];
        s.push_back('{10'h010, mac[31:0], 1'b1});
        s.push_back('{10'h011, {16'h0, mac[47:32]}, 1'b1});
        s.push_back('{10'h008, 32'd64, 1'b1});
        s.push_back('{10'h002, 32'h7F, 1'b1});
        s.push_back('{10'h00A, 32'd40, 1'b1});
        if (PHY_BUILD) begin
            s.push_back('{10'h00C, {19'h0, phy_reg_i, 3'h0, 5'd1}, 1'b1});
            s.push_back('{10'h00D, {16'h0, phy_dat_i}, 1'b1});
            s.push_back('{10'h00B, 32'h4, 1'b1});
            for (int i = 0; i < n_reads; i++) s.push_back('{10'h00F, 32'h0, 1'b0});
        end
        if (with_moder) s.push_back('{10'h000, 32'hA403, 1'b1});
        for (int i = 0; i < s.size(); i++)
            if (n == 0 || i < n) exp_q.push_back(s[i]);
    endtask

    task automatic drain(input string tag);
        log_t r;
        acc_t e;
        while (log_rd < acc_log.size()) begin
            r = acc_log[log_rd];
            log_rd++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL %s extra access: got adr %0h expected none", tag, r.adr);
            end else begin
                e = exp_q.pop_front();
                chk({tag, " adr"}, r.adr, e.adr);
                chk({tag, " we"}, r.we, e.we);
                if (e.we) chk({tag, " dat"}, r.dat, e.dat);
                chk({tag, " sel"}, r.sel, 4'hF);
                chk({tag, " stable"}, r.stable, 1'b1);
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 4000) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk({tag, " finished in time"}, busy_o, 1'b0);
    endtask

    task automatic run(input logic [47:0] mac, input int dly, input int err_step, input int n_reads,
                       input int busy_n, input logic with_moder, input int n_acc,
                       input logic exp_done, input logic exp_err, input string tag);
        ack_dly = dly;
        err_at = (err_step < 0) ? -1 : acc_cnt + err_step;
        busy_until = rd_cnt + busy_n;
        mac_addr_i = mac;
        push_exp(mac, n_reads, with_moder, n_acc);
        start_i = 1'b1;
        @(negedge wb_clk_i);
        chk({tag, " launch busy/done/err"}, {busy_o, done_o, err_o}, 3'b100);
        wait_idle(tag);
        start_i = 1'b0;
        @(negedge wb_clk_i);
        drain(tag);
        chk({tag, " done_o"}, done_o, exp_done);
        chk({tag, " err_o"}, err_o, exp_err);
        chk({tag, " bus idle"}, {m_wb_cyc_o, m_wb_stb_o}, 2'b00);
        chk({tag, " missing accesses"}, exp_q.size(), 0);
    endtask

    vec_t vecs[6];
    int   n, base;

    initial begin
        vecs[0] = '{48'h0A1B2C3D4E5F, 0, -1, 0, 1'b1, 1'b0};
        vecs[1] = '{48'h0A1B2C3D4E5F, 3, -1, 0, 1'b1, 1'b0};
        vecs[2] = '{48'h00000000_0001, 0,  2, 3, 1'b0, 1'b1};
        vecs[3] = '{48'hFFFFFFFFFFFF, 1, -1, 0, 1'b1, 1'b0};
        vecs[4] = '{48'h123456789ABC, 2,  0, 1, 1'b0, 1'b1};
        vecs[5] = '{48'h5A5AA5A5C3C3, 0, -1, 0, 1'b1, 1'b0};

        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("reset ctl", {m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_sel_o, busy_o, done_o, err_o}, '0);
        chk("reset adr", m_wb_adr_o, '0);
        chk("reset dat", m_wb_dat_o, '0);
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);

        for (int i = 0; i < 6; i++)
            run(vecs[i].mac, vecs[i].dly, vecs[i].err_step, 1, 0, 1'b1, vecs[i].n_acc,
                vecs[i].exp_done, vecs[i].exp_err, $sformatf("vec%0d", i));

        // start re-rise and input changes while busy must not disturb the sequence
        ack_dly = 2; err_at = -1; busy_until = rd_cnt;
        mac_addr_i = 48'h112233445566;
        push_exp(mac_addr_i, 1, 1'b1, 0);
        start_i = 1'b1;
        @(negedge wb_clk_i);
        chk("busy-restart launch", {busy_o, done_o, err_o}, 3'b100);
        repeat (6) @(negedge wb_clk_i);
        start_i = 1'b0;
        mac_addr_i = 48'hDEADBEEFCAFE;
        phy_dat_i = 16'h1234;
        repeat (3) @(negedge wb_clk_i);
        start_i = 1'b1;
        wait_idle("busy-restart");
        start_i = 1'b0;
        @(negedge wb_clk_i);
        drain("busy-restart");
        chk("busy-restart done_o", done_o, 1'b1);
        chk("busy-restart missing accesses", exp_q.size(), 0);
        phy_dat_i = 16'hBEEF;

        // reset during the wait of access 2, start held high through reset
        ack_dly = 3; err_at = -1; busy_until = rd_cnt;
        mac_addr_i = 48'h0A1B2C3D4E5F;
        push_exp(mac_addr_i, 1, 1'b1, 0);
        base = acc_cnt;
        start_i = 1'b1;
        n = 0;
        while (!(m_wb_stb_o && m_wb_adr_o == 10'h011) && n < 200) begin
            @(negedge wb_clk_i);
            n++;
        end
        chk("rst reached access 2", n < 200, 1'b1);
        wb_rst_n_i = 1'b0;
        @(negedge wb_clk_i);
        chk("rst mid ctl", {m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, m_wb_sel_o, busy_o, done_o, err_o}, '0);
        chk("rst mid adr/dat", {m_wb_adr_o, m_wb_dat_o}, '0);
        drain("rst");
        exp_q.delete();
        repeat (2) @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        repeat (10) @(negedge wb_clk_i);
        chk("rst held start no launch", {busy_o, m_wb_cyc_o}, 2'b00);
        chk("rst completed accesses", acc_cnt - base, 1);
        start_i = 1'b0;
        @(negedge wb_clk_i);
        run(48'h0A1B2C3D4E5F, 0, -1, 1, 0, 1'b1, 0, 1'b1, 1'b0, "post-rst");

`ifdef ETH_CFG_PHY_EN
        phy_reg_i = 5'd1;
        run(48'h0A1B2C3D4E5F, 0, -1, 6, 5, 1'b1, 0, 1'b1, 1'b0, "phy poll");
        run(48'h0A1B2C3D4E5F, 1, -1, POLL_MAX, 1000, 1'b0, 0, 1'b0, 1'b1, "phy stuck");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end
endmodule
